// File: rtl/fadd_operand_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fadd_operand_stage
// Brief    : Registered issue stage ahead of the single-precision adder.
//            It folds SUB into a sign flip, flushes denormals, bypasses
//            NaN/Inf operands and presents the operands through a 2-entry skid.
// Revision : 1.0 - initial release
// ============================================================================
module fadd_operand_stage #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      first_operand,
  output logic [31:0]      second_operand,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_bypass,
  output logic [31:0]      out_bypass_result,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [31:0] c_qnan = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] tag;
    logic             bypass;
    logic [31:0]      bypass_result;
  } entry_t;

  // State bit 0 is the main-register valid, bit 1 the skid-register valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  entry_t           r_main;
  entry_t           r_skid;
  entry_t           w_in_entry;
  logic [CNT_W-1:0] r_issue_count;

  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_load_main_in;
  logic        w_load_main_skid;
  logic        w_load_skid;

  logic [31:0] w_b_signed;
  logic [31:0] w_a_flush;
  logic [31:0] w_b_flush;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_bypass;
  logic [31:0] w_bypass_result;

  // ---------------------------------------------------------------- preprocess
  assign w_b_signed = {in_b[31] ^ in_sub, in_b[30:0]};
  assign w_a_flush  = (in_a[30:23] == 8'h00)       ? {in_a[31], 31'b0}       : in_a;
  assign w_b_flush  = (w_b_signed[30:23] == 8'h00) ? {w_b_signed[31], 31'b0} : w_b_signed;

  assign w_a_nan = (&w_a_flush[30:23]) & (|w_a_flush[22:0]);
  assign w_b_nan = (&w_b_flush[30:23]) & (|w_b_flush[22:0]);
  assign w_a_inf = (&w_a_flush[30:23]) & ~(|w_a_flush[22:0]);
  assign w_b_inf = (&w_b_flush[30:23]) & ~(|w_b_flush[22:0]);

  always_comb begin
    w_bypass        = 1'b0;
    w_bypass_result = 32'h0;
    if (w_a_nan || w_b_nan) begin
      w_bypass        = 1'b1;
      w_bypass_result = c_qnan;
    end else if (w_a_inf && w_b_inf) begin
      // inf - inf is invalid; same-signed infinities just propagate.
      w_bypass        = 1'b1;
      w_bypass_result = (w_a_flush[31] != w_b_flush[31]) ? c_qnan : w_a_flush;
    end else if (w_a_inf) begin
      w_bypass        = 1'b1;
      w_bypass_result = w_a_flush;
    end else if (w_b_inf) begin
      w_bypass        = 1'b1;
      w_bypass_result = w_b_flush;
    end
  end

  always_comb begin
    w_in_entry.op_a          = w_a_flush;
    w_in_entry.op_b          = w_b_flush;
    w_in_entry.tag           = in_tag;
    w_in_entry.bypass        = w_bypass;
    w_in_entry.bypass_result = w_bypass_result;
  end

  // ------------------------------------------------------------ handshake/FSM
  assign in_ready   = ~r_state[1];
  assign out_valid  = r_state[0];
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path can move.
        if (w_out_fire) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main        <= '0;
      r_skid        <= '0;
      r_issue_count <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_entry;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
      if (w_in_fire) begin
        r_issue_count <= r_issue_count + CNT_W'(1);
      end
    end
  end

  assign first_operand     = r_main.op_a;
  assign second_operand    = r_main.op_b;
  assign out_tag           = r_main.tag;
  assign out_bypass        = r_main.bypass;
  assign out_bypass_result = r_main.bypass_result;
  assign issue_count       = r_issue_count;

endmodule
`default_nettype wire

// File: tb/tb_fadd_operand_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for fadd_operand_stage: directed requests push expected
// entries; a negedge monitor pops and compares on every output transfer.
module tb_fadd_operand_stage;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      first_operand;
  logic [31:0]      second_operand;
  logic [TAG_W-1:0] out_tag;
  logic             out_bypass;
  logic [31:0]      out_bypass_result;
  logic [CNT_W-1:0] issue_count;

  fadd_operand_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_a              (in_a),
    .in_b              (in_b),
    .in_sub            (in_sub),
    .in_tag            (in_tag),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .first_operand     (first_operand),
    .second_operand    (second_operand),
    .out_tag           (out_tag),
    .out_bypass        (out_bypass),
    .out_bypass_result (out_bypass_result),
    .issue_count       (issue_count)
  );

  always #5 clk = ~clk;

  typedef logic [100:0] entry_t;  // {first, second, tag, bypass, result}

  entry_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic entry_t cur_out();
    return {first_operand, second_operand, out_tag, out_bypass, out_bypass_result};
  endfunction

  // Monitor: scoreboard pop on transfer, plus stability while stalled.
  entry_t prev_out;
  logic   prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_stable", 128'(cur_out()), 128'(prev_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 128'(cur_out()), 128'(0));
          if (cur_out() == '0) begin
            n_fail++;
            $display("FAIL unexpected_output: got output with empty scoreboard, required none");
          end
        end else begin
          chk("scoreboard", 128'(cur_out()), 128'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur_out();
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [3:0] tag, input logic [31:0] e_first,
                      input logic [31:0] e_second, input logic e_byp,
                      input logic [31:0] e_res);
    bit accepted = 0;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({e_first, e_second, tag, e_byp, e_res});
        accepted = 1;
      end
    end
    if (!accepted) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: tag %0d not accepted in 40 cycles, required acceptance", tag);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(name, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Request offered during reset must be ignored.
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_tag = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_fields",    128'(cur_out()), 128'(0));
    chk("rst_count",     128'(issue_count), 128'(0));
    @(posedge clk); #1;

    // Single add with latency check.
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd3, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0);
    @(negedge clk);
    chk("lat1_out_valid", 128'(out_valid), 128'(1));
    chk("lat1_count",     128'(issue_count), 128'(1));
    @(posedge clk); #1;

    // Back-to-back preprocessing / classification vectors.
    send(32'h4040_0000, 32'h4000_0000, 1'b1, 4'd4, 32'h4040_0000, 32'hC000_0000, 1'b0, 32'h0);
    send(32'h3F80_0000, 32'h8000_0005, 1'b0, 4'd5, 32'h3F80_0000, 32'h8000_0000, 1'b0, 32'h0);
    send(32'h7F80_0001, 32'h3F80_0000, 1'b0, 4'd6, 32'h7F80_0001, 32'h3F80_0000, 1'b1, 32'h7FC0_0000);
    send(32'h7F80_0000, 32'h7F80_0000, 1'b1, 4'd7, 32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7FC0_0000);
    send(32'hFF80_0000, 32'h3F80_0000, 1'b0, 4'd8, 32'hFF80_0000, 32'h3F80_0000, 1'b1, 32'hFF80_0000);
    send(32'h0000_0003, 32'h0000_0000, 1'b1, 4'd9, 32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0);
    send(32'h3F80_0000, 32'h7F80_0000, 1'b1, 4'd10, 32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'hFF80_0000);
    send(32'h4000_0000, 32'h7FC0_0001, 1'b1, 4'd11, 32'h4000_0000, 32'hFFC0_0001, 1'b1, 32'h7FC0_0000);
    send(32'hFF80_0000, 32'h7F80_0000, 1'b1, 4'd12, 32'hFF80_0000, 32'hFF80_0000, 1'b1, 32'hFF80_0000);
    send(32'h8000_0000, 32'h0000_0000, 1'b0, 4'd13, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0);
    drain("drain_vectors", 10);
    chk("count_vectors", 128'(issue_count), 128'(11));

    // Back-pressure: fill to FULL, hold third request, then release.
    do_reset();
    out_ready = 1'b0;
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0);
    send(32'h4040_0000, 32'h4000_0000, 1'b0, 4'd2, 32'h4040_0000, 32'h4000_0000, 1'b0, 32'h0);
    fork
      send(32'h4080_0000, 32'h4000_0000, 1'b1, 4'd3, 32'h4080_0000, 32'hC000_0000, 1'b0, 32'h0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", 128'(in_ready), 128'(0));
          chk("bp_head_tag",     128'(out_tag),  128'(1));
          chk("bp_count_held",   128'(issue_count), 128'(2));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    // Tag 3 was accepted on the edge that popped tag 2; it must follow at once.
    @(negedge clk);
    chk("bp_tag3_next", 128'(out_valid), 128'(1));
    drain("bp_drain", 2);
    chk("bp_count", 128'(issue_count), 128'(3));
    @(posedge clk); #1;

    // Reset while FULL.
    out_ready = 1'b0;
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd9,  32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h0);
    send(32'h3F80_0000, 32'h3F80_0000, 1'b1, 4'd10, 32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0);
    chk("full_in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b1; in_tag = 4'd11;
    do_reset();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_in_ready",  128'(in_ready),  128'(1));
    chk("mid_rst_count",     128'(issue_count), 128'(0));
    chk("mid_rst_fields",    128'(cur_out()), 128'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h4000_0000, 32'h4040_0000, 1'b0, 4'd12, 32'h4000_0000, 32'h4040_0000, 1'b0, 32'h0);
    @(negedge clk);
    chk("post_rst_valid", 128'(out_valid), 128'(1));
    chk("post_rst_count", 128'(issue_count), 128'(1));
    @(posedge clk); #1;
    drain("post_rst_drain", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
